// File: rtl/piso_buffer.sv
`default_nettype none
// ============================================================================
// Module      : piso_buffer
// Description : Parallel-in, single-out slot buffer with a registered
//               valid/pop output stage. Define PISO_RR_EN for round-robin
//               selection; the default build uses lowest-index priority.
// Revision    : 1.0 - initial release
// ============================================================================
module piso_buffer #(
  parameter int WIDTH  = 32,
  parameter int LENGTH = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [LENGTH-1:0]                we,
  input  logic [LENGTH-1:0][WIDTH-1:0]     d_inp,
  output logic [LENGTH-1:0]                used_pos,
  output logic [WIDTH-1:0]                 d_oup,
  output logic                             oup_valid,
  output logic [$clog2(LENGTH)-1:0]        oup_idx,
  input  logic                             pop,
  output logic [$clog2(LENGTH):0]          num_used,
  output logic                             full,
  output logic                             wr_drop
);

  localparam int IDX_W = $clog2(LENGTH);
  localparam int CNT_W = $clog2(LENGTH) + 1;

  logic [LENGTH-1:0][WIDTH-1:0] r_data;
  logic [LENGTH-1:0]            r_used;
  logic [WIDTH-1:0]             r_dout;
  logic                         r_valid;
  logic [IDX_W-1:0]             r_idx;
  logic [CNT_W-1:0]             r_num;
  logic                         r_full;
  logic                         r_drop;

  logic                         w_xfer;
  logic [LENGTH-1:0]            w_xmask;
  logic [LENGTH-1:0]            w_cand;
  logic [LENGTH-1:0]            w_accept;
  logic [LENGTH-1:0]            w_used_nxt;
  logic                         w_drop_nxt;
  logic                         w_sel_en;
  logic [IDX_W-1:0]             w_pick;
  logic                         w_pick_ok;
  logic [CNT_W-1:0]             w_num_nxt;

  function automatic logic [CNT_W-1:0] popcount(input logic [LENGTH-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < LENGTH; i++) begin
      n = n + CNT_W'(v[i]);
    end
    return n;
  endfunction

  // Slot bookkeeping: a transferring slot is free for a same-edge write,
  // and occupied slots other than the presented one are the candidates.
  always_comb begin
    w_xfer  = r_valid & pop;
    w_xmask = '0;
    if (w_xfer) begin
      w_xmask[r_idx] = 1'b1;
    end
    w_cand     = r_used & ~w_xmask;
    w_accept   = we & ~w_cand;
    w_drop_nxt = |(we & w_cand);
    w_used_nxt = w_cand | w_accept;
    w_num_nxt  = popcount(w_used_nxt);
    w_sel_en   = ~r_valid | w_xfer;
  end

`ifdef PISO_RR_EN
  logic [IDX_W-1:0] r_rr;
  logic [IDX_W-1:0] w_rr_base;

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i);
    if (i == IDX_W'(LENGTH - 1)) begin
      return '0;
    end
    return i + 1'b1;
  endfunction

  always_comb begin
    w_rr_base = r_rr;
    if (w_xfer) begin
      w_rr_base = wrap_inc(r_idx);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr <= '0;
    end else if (w_xfer) begin
      r_rr <= wrap_inc(r_idx);
    end
  end

  // Search downward so the closest candidate at or after the pointer wins.
  always_comb begin
    int j;
    w_pick    = '0;
    w_pick_ok = 1'b0;
    for (int k = LENGTH - 1; k >= 0; k--) begin
      j = int'(w_rr_base) + k;
      if (j >= LENGTH) begin
        j = j - LENGTH;
      end
      if (w_cand[j]) begin
        w_pick    = IDX_W'(j);
        w_pick_ok = 1'b1;
      end
    end
  end
`else
  always_comb begin
    w_pick    = '0;
    w_pick_ok = 1'b0;
    for (int i = LENGTH - 1; i >= 0; i--) begin
      if (w_cand[i]) begin
        w_pick    = IDX_W'(i);
        w_pick_ok = 1'b1;
      end
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data  <= '0;
      r_used  <= '0;
      r_dout  <= '0;
      r_valid <= 1'b0;
      r_idx   <= '0;
      r_num   <= '0;
      r_full  <= 1'b0;
      r_drop  <= 1'b0;
    end else begin
      r_used <= w_used_nxt;
      r_num  <= w_num_nxt;
      r_full <= &w_used_nxt;
      r_drop <= w_drop_nxt;
      for (int i = 0; i < LENGTH; i++) begin
        if (w_accept[i]) begin
          r_data[i] <= d_inp[i];
        end else if (w_xmask[i]) begin
          r_data[i] <= '0;
        end
      end
      if (w_sel_en) begin
        r_valid <= w_pick_ok;
        r_idx   <= w_pick_ok ? w_pick : '0;
        r_dout  <= w_pick_ok ? r_data[w_pick] : '0;
      end
    end
  end

  assign used_pos  = r_used;
  assign d_oup     = r_dout;
  assign oup_valid = r_valid;
  assign oup_idx   = r_idx;
  assign num_used  = r_num;
  assign full      = r_full;
  assign wr_drop   = r_drop;

endmodule
`default_nettype wire
